fb_write_scheduler: RTL
=======================

FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, frame buffer address width.
REQ-002 SHALL have parameter DATA_W, default 4, pixel width.
REQ-003 SHALL have parameter FB_PIXELS, default 19200, pixel count cleared (1..2**ADDR_W).
REQ-004 SHALL have port gpu_clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port gpu_rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port clr_start  in  1  single-cycle request to fill frame buffer.
REQ-007 SHALL have port clr_color  in  DATA_W  fill value, sampled with accepted clr_start.
REQ-008 SHALL have port clr_busy  out  1  clear sequence in progress.
REQ-009 SHALL have port clr_done  out  1  one-cycle pulse, final clear write issued.
REQ-010 SHALL have port draw_valid  in  1  draw pixel write request.
REQ-011 SHALL have port draw_addr  in  ADDR_W  draw pixel address.
REQ-012 SHALL have port draw_data  in  DATA_W  draw pixel value.
REQ-013 SHALL have port draw_ready  out  1  draw request accepted this cycle when valid.
REQ-014 SHALL have ports fb_we (1), fb_addr (ADDR_W), fb_data (DATA_W), all out, driving the frame buffer write port.

Function
REQ-015 SHALL implement states IDLE and CLEAR; reset state IDLE.
REQ-016 In IDLE, clr_start SHALL latch clr_color, zero the clear counter, and enter CLEAR next cycle; clr_busy rises the same edge.
REQ-017 clr_start in CLEAR SHALL be ignored (no restart, color unchanged).
REQ-018 draw_ready SHALL be combinational: 1 in IDLE; in CLEAR, 1 only when arbitration token = DRAW.
REQ-019 Draw handshake: transfer occurs when draw_valid && draw_ready; requester holds addr/data until transfer.
REQ-020 In CLEAR, a clear write SHALL issue each cycle the draw transfer does not occur.
REQ-021 Token: after a clear write -> DRAW; after a draw transfer -> CLEAR; draw_valid low keeps clear writing every cycle.
REQ-022 fb_we/fb_addr/fb_data SHALL be registered: one-cycle latency from transfer/clear issue; at most one write per cycle.
REQ-023 Clear writes SHALL cover addresses 0..FB_PIXELS-1 in increasing order, each exactly once, data = latched color.
REQ-024 Counter SHALL be ADDR_W+1 bits internally so FB_PIXELS = 2**ADDR_W terminates without wrap.
REQ-025 Issuing address FB_PIXELS-1 SHALL return state to IDLE; clr_done pulses and clr_busy falls in the cycle fb_we presents that address.
REQ-026 When no write is issued, fb_we SHALL be 0; fb_addr/fb_data hold last value.

Reset
REQ-027 Reset SHALL force fb_we=0, fb_addr=0, fb_data=0, clr_busy=0, clr_done=0, clip_err=0 (if present), token=CLEAR, counter=0, state IDLE.
REQ-028 Reset during CLEAR SHALL abort the sequence with no clr_done and no further clear writes.
REQ-029 draw_ready SHALL be 0 while gpu_rst_n is low.

Configuration
REQ-030 Macro FB_ADDR_CLIP_EN defined: draw transfers with draw_addr >= FB_PIXELS SHALL complete handshake but produce fb_we=0, and set sticky output clip_err (1 bit, cleared only by reset).
REQ-031 Macro FB_ADDR_CLIP_EN undefined: all draw transfers forwarded unchanged; clip_err port absent.

Verification (FB_PIXELS=8)
REQ-032 Idle draw: draw_valid=1, addr=5, data=0xA -> next cycle fb_we=1, fb_addr=5, fb_data=0xA; draw_ready=1 throughout.
REQ-033 Clear only: clr_start with clr_color=0x3 -> 8 consecutive fb_we cycles, addrs 0..7, data 0x3; clr_done with addr 7; clr_busy low after.
REQ-034 Contention: draw_valid held high during clear, addr 2, data 0xF -> fb writes alternate clear/draw; clear finishes in 16 cycles; all 8 clear addrs seen once.
REQ-035 Restart ignore: clr_start with color 0x9 mid-clear -> remaining clear data stays original color, single clr_done.
REQ-036 Reset mid-clear after 3 writes -> fb_we=0 next cycle, no clr_done, clr_busy=0, draw_ready=1 once reset released.
REQ-037 With FB_ADDR_CLIP_EN: draw addr=8 -> handshake completes, fb_we stays 0, clip_err=1 until reset.

Source files
------------

// File: rtl/fb_write_scheduler.sv
// rtl/fb_write_scheduler.sv - frame buffer write arbiter between clear sequencer and draw requests (optional FB_ADDR_CLIP_EN)
module fb_write_scheduler #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 4,
    parameter int FB_PIXELS = 19200
) (
    input  logic              gpu_clk,
    input  logic              gpu_rst_n,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    input  logic              draw_valid,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_data,
    output logic              draw_ready,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
`ifdef FB_ADDR_CLIP_EN
    output logic              clip_err,
`endif
    output logic [DATA_W-1:0] fb_data
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Token says who owns the write port next cycle while clearing.
    typedef enum logic {
        TOK_CLEAR = 1'b0,
        TOK_DRAW  = 1'b1
    } token_t;

    // Counter is one bit wider than the address so a full-size buffer ends without wrapping.
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(FB_PIXELS - 1);

    state_t              state_q, state_d;
    token_t              token_q, token_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   color_q, color_d;
    logic                fb_we_q, fb_we_d;
    logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
    logic [DATA_W-1:0]   fb_data_q, fb_data_d;
    logic                clr_done_q, clr_done_d;
    logic                draw_xfer;
    logic                clear_issue;
    logic                draw_clip;
`ifdef FB_ADDR_CLIP_EN
    localparam logic [ADDR_W:0] PIX_LIMIT = (ADDR_W+1)'(FB_PIXELS);
    logic                clip_err_q, clip_err_d;
`endif

    // Draw acceptance: always in IDLE, only on its token turn while clearing, never in reset.
    always_comb begin
        draw_ready = 1'b0;
        if (gpu_rst_n) begin
            draw_ready = (state_q == ST_IDLE) || (token_q == TOK_DRAW);
        end
    end

    // Next-state, arbitration and write-port computation.
    always_comb begin
        state_d     = state_q;
        token_d     = token_q;
        cnt_d       = cnt_q;
        color_d     = color_q;
        fb_we_d     = 1'b0;
        fb_addr_d   = fb_addr_q;
        fb_data_d   = fb_data_q;
        clr_done_d  = 1'b0;
        draw_xfer   = draw_valid && draw_ready;
        clear_issue = (state_q == ST_CLEAR) && !draw_xfer;
`ifdef FB_ADDR_CLIP_EN
        draw_clip   = ({1'b0, draw_addr} >= PIX_LIMIT);
        clip_err_d  = clip_err_q | (draw_xfer & draw_clip);
`else
        draw_clip   = 1'b0;
`endif

        if (draw_xfer) begin
            token_d = TOK_CLEAR;
            if (!draw_clip) begin
                fb_we_d   = 1'b1;
                fb_addr_d = draw_addr;
                fb_data_d = draw_data;
            end
        end else if (clear_issue) begin
            token_d   = TOK_DRAW;
            fb_we_d   = 1'b1;
            fb_addr_d = cnt_q[ADDR_W-1:0];
            fb_data_d = color_q;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_d    = ST_IDLE;
                clr_done_d = 1'b1;
            end
        end

        // A start request while already clearing is dropped on purpose.
        if ((state_q == ST_IDLE) && clr_start) begin
            state_d = ST_CLEAR;
            color_d = clr_color;
            cnt_d   = '0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge gpu_clk) begin
        if (!gpu_rst_n) begin
            state_q    <= ST_IDLE;
            token_q    <= TOK_CLEAR;
            cnt_q      <= '0;
            color_q    <= '0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            token_q    <= token_d;
            cnt_q      <= cnt_d;
            color_q    <= color_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
            clr_done_q <= clr_done_d;
        end
    end

`ifdef FB_ADDR_CLIP_EN
    // Sticky out-of-range draw flag, cleared only by reset.
    always_ff @(posedge gpu_clk) begin
        if (!gpu_rst_n) begin
            clip_err_q <= 1'b0;
        end else begin
            clip_err_q <= clip_err_d;
        end
    end
    assign clip_err = clip_err_q;
`endif

    assign clr_busy = (state_q == ST_CLEAR);
    assign clr_done = clr_done_q;
    assign fb_we    = fb_we_q;
    assign fb_addr  = fb_addr_q;
    assign fb_data  = fb_data_q;

endmodule
